// File: rtl/dsp_sys_arr_pkg.sv
// ============================================================================
// Module  : dsp_sys_arr_pkg
// Brief   : Shared types and helpers for the systolic array datapath:
//           the single-precision word type, the result-drain state encoding
//           and an Inf/NaN classifier.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package dsp_sys_arr_pkg;

    localparam int SNGL_FLT_SIZE = 32;

    typedef logic [SNGL_FLT_SIZE-1:0] single_float;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } drain_state_t;

    // An all-ones exponent marks infinity or NaN regardless of mantissa.
    function automatic logic is_inf_nan(input single_float f);
        return (f[30:23] == 8'hFF);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sys_arr_result_drain.sv
// ============================================================================
// Module  : sys_arr_result_drain
// Brief   : Snapshots the MxK accumulated results of the systolic array on the
//           rising edge of the aggregate comp_done, then streams them out
//           row-major, one single_float per valid/ready beat, tagged with
//           row/col and a last flag. A one-cycle drain_done pulse follows the
//           final beat. Optional Inf/NaN flagging is enabled by defining
//           DRAIN_NAN_CHECK_EN (adds out_nan and nan_seen ports).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sys_arr_result_drain
    import dsp_sys_arr_pkg::*;
#(
    parameter  int M      = 2,
    parameter  int K      = 2,
    localparam int RIDX_W = (M > 1) ? $clog2(M) : 1,
    localparam int CIDX_W = (K > 1) ? $clog2(K) : 1
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic                      comp_done,
    input  logic                      error_in,
    input  logic [M*K*SNGL_FLT_SIZE-1:0] res_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SNGL_FLT_SIZE-1:0]  out_dat,
    output logic [RIDX_W-1:0]         out_row,
    output logic [CIDX_W-1:0]         out_col,
    output logic                      out_last,
    output logic                      busy,
    output logic                      drain_done,
    output logic                      err_out,
    output logic                      overrun
`ifdef DRAIN_NAN_CHECK_EN
    ,
    output logic                      out_nan,
    output logic                      nan_seen
`endif
);

    localparam int c_NUM   = M * K;
    localparam int c_IDX_W = (c_NUM > 1) ? $clog2(c_NUM) : 1;

    localparam logic [1:0] c_ST_IDLE   = IDLE;
    localparam logic [1:0] c_ST_STREAM = STREAM;
    localparam logic [1:0] c_ST_DONE   = DONE;

    localparam logic [RIDX_W-1:0] c_ROW_MAX = RIDX_W'(M - 1);
    localparam logic [CIDX_W-1:0] c_COL_MAX = CIDX_W'(K - 1);

    logic [1:0]         r_state;
    single_float        r_buf [c_NUM];
    logic [RIDX_W-1:0]  r_row;
    logic [CIDX_W-1:0]  r_col;
    logic               r_err;
    logic               r_comp_done_q;
    logic               r_overrun;

    logic               w_trigger;
    logic               w_valid;
    logic               w_last;
    logic               w_xfer;
    logic [c_IDX_W-1:0] w_idx;

    // Only a fresh rise of comp_done starts a drain; a held level is ignored.
    assign w_trigger = comp_done & ~r_comp_done_q;
    assign w_valid   = (r_state == c_ST_STREAM);
    assign w_last    = w_valid && (r_row == c_ROW_MAX) && (r_col == c_COL_MAX);
    assign w_xfer    = w_valid && out_ready;
    assign w_idx     = c_IDX_W'(r_row) * c_IDX_W'(K) + c_IDX_W'(r_col);

    assign out_valid  = w_valid;
    assign out_dat    = r_buf[w_idx];
    assign out_row    = r_row;
    assign out_col    = r_col;
    assign out_last   = w_last;
    assign busy       = (r_state != c_ST_IDLE);
    assign drain_done = (r_state == c_ST_DONE);
    assign err_out    = r_err;
    assign overrun    = r_overrun;

    // Drain sequencer: capture the whole matrix, then walk it row-major.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state <= c_ST_IDLE;
            r_row   <= '0;
            r_col   <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < c_NUM; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_trigger) begin
                        for (int i = 0; i < c_NUM; i++) begin
                            r_buf[i] <= res_in[i*SNGL_FLT_SIZE +: SNGL_FLT_SIZE];
                        end
                        r_err   <= error_in;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_state <= c_ST_STREAM;
                    end
                end
                c_ST_STREAM: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            r_state <= c_ST_DONE;
                        end else if (r_col == c_COL_MAX) begin
                            r_col <= '0;
                            r_row <= r_row + RIDX_W'(1);
                        end else begin
                            r_col <= r_col + CIDX_W'(1);
                        end
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Edge history for comp_done and the sticky overrun flag (cleared only by reset).
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_comp_done_q <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_comp_done_q <= comp_done;
            if (w_trigger && (r_state != c_ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
        end
    end

`ifdef DRAIN_NAN_CHECK_EN
    logic r_nan_seen;

    assign out_nan  = is_inf_nan(out_dat);
    assign nan_seen = r_nan_seen;

    // Per-matrix Inf/NaN flag: cleared on capture, set by any accepted bad beat.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_nan_seen <= 1'b0;
        end else if ((r_state == c_ST_IDLE) && w_trigger) begin
            r_nan_seen <= 1'b0;
        end else if (w_xfer && out_nan) begin
            r_nan_seen <= 1'b1;
        end
    end
`endif

endmodule

`default_nettype wire
